iicmb_wb_sequencer: RTL and testbench
=====================================

// Module: iicmb_wb_sequencer
// PURPOSE
// Hardware Wishbone master that sequences the iicmb_m_wb I2C controller in place of software register pokes.
// - Accepts one I2C transaction request: bus, 7-bit address, direction, length.
// - Issues the CSR/DPR/CMDR register accesses and waits on irq after each command.
// - Reads CMDR after every irq to clear it and check status.
// - Write data enters and read data leaves on valid/ready byte streams.
// PARAMETERS
// LEN_W        6      width of byte-count field; max transfer 2**LEN_W-1 bytes
// BUS_W        4      width of bus-select field (iicmb g_bus_num <= 2**BUS_W)
// IRQ_TIMEOUT  65535  clk_i cycles to wait for irq before aborting
// PORTS
// clk_i        in   1      clock
// rst_n_i      in   1      reset; asynchronous, active-low
// req_valid_i  in   1      transaction request valid
// req_ready_o  out  1      sequencer idle, request accepted when valid&ready
// req_bus_i    in   BUS_W  iicmb bus number
// req_addr_i   in   7      I2C slave address
// req_rw_i     in   1      0=write, 1=read
// req_len_i    in   LEN_W  data byte count (0 = address-only probe)
// wr_data_i    in   8      write byte stream data
// wr_valid_i   in   1      write byte valid
// wr_ready_o   out  1      write byte taken when valid&ready
// rd_data_o    out  8      read byte stream data
// rd_valid_o   out  1      read byte valid, held until rd_ready_i
// rd_ready_i   in   1      downstream accepts read byte
// done_o       out  1      one-cycle pulse at end of transaction
// status_o     out  2      00 ok, 01 NAK, 10 arbitration lost, 11 timeout/error; valid with done_o, held until next request
// cyc_o/stb_o  out  1      Wishbone cycle/strobe (tied together)
// we_o         out  1      Wishbone write enable
// adr_o        out  2      register: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR
// dat_o        out  8      Wishbone write data
// dat_i        in   8      Wishbone read data
// ack_i        in   1      Wishbone acknowledge
// irq_i        in   1      iicmb interrupt request
// BEHAVIOUR
// Reset values: all outputs 0 except req_ready_o=1; core_en flag=0; state=IDLE.
// Reset mid-transaction drops cyc_o/stb_o immediately. No stop is issued.
// WB access: cyc/stb/we/adr/dat registered and held until the cycle ack_i=1 is sampled.
// - cyc/stb deassert the next cycle; at most one access in flight.
// - dat_i is captured on the ack cycle.
// Command write (CMDR) is followed by WAIT_IRQ:
// - Counter loads IRQ_TIMEOUT and decrements.
// - On irq_i=1: read CMDR. Status bits: 7 DON, 6 NAK, 5 AL, 4 ERR.
// - Counter reaches 0 -> status 11, go to ABORT.
// States: IDLE -> [EN_CSR once after reset: CSR<=0xC0] -> BUS (DPR<=bus, CMDR<=0x06) -> START (CMDR<=0x04)
// -> ADDR (DPR<={addr,rw}, CMDR<=0x01) -> WR_BYTE* | RD_BYTE* -> STOP (CMDR<=0x05) -> DONE -> IDLE.
// WR_BYTE: wr_ready_o=1 for exactly one cycle per byte once DPR write may begin. Stall while wr_valid_i=0.
// - Then DPR<=byte, CMDR<=0x01.
// RD_BYTE: CMDR<=0x02 (ACK) for bytes 0..len-2, CMDR<=0x03 (NACK) for the last byte.
// - After irq, read DPR, present on rd_data_o.
// - Next command is not issued until rd_ready_i consumes the byte (backpressure).
// len=0: START, ADDR, STOP only; no stream handshakes.
// NAK on address or data byte: skip remaining bytes, issue STOP, status 01.
// AL: no STOP (bus not owned), status 10. ERR bit or timeout: status 11.
// ABORT drops cyc/stb if mid-access, then DONE. core_en is cleared so CSR is re-written next time.
// Request accepted only in IDLE; req_* latched on accept; byte counter counts down from len.
// done_o and req_ready_o rise together in the cycle after the final CMDR status read.
// TESTING
// 1. Reset, req bus0 addr 0x22 write len 32, stream 0..31 -> WB sequence CSR=C0, DPR=00, CMDR=06, CMDR=04, DPR=44, CMDR=01.
//    Then 32x(DPR=n, CMDR=01), CMDR=05. Slave sees 0..31. done_o with status 00.
// 2. Read 0x22 len 32, slave supplies 100..131 -> DPR=45; 31 CMDR=02 then one CMDR=03.
//    rd stream 100..131 in order. status 00. No second CSR write.
// 3. Read len 4 with rd_ready_i low 50 cycles on byte 2 -> no CMDR issued during stall; all 4 bytes delivered intact.
// 4. Write to absent address 0x10 -> address NAK, CMDR=05 issued, wr_ready_o never asserted, status 01.
// 5. irq_i held low (slave stretches SCL), IRQ_TIMEOUT=100 -> done_o 100..102 cycles after CMDR ack, status 11.
// 6. Assert rst_n_i during WR_BYTE with cyc_o=1 -> cyc_o=0 asynchronously, req_ready_o=1. Next request re-writes CSR=C0.

Source files
------------

// File: rtl/iicmb_wb_sequencer.sv
// rtl/iicmb_wb_sequencer.sv - Wishbone master that drives one iicmb_m_wb I2C transaction per request
// Register writes, irq waits and CMDR status reads are sequenced by a single FSM.
module iicmb_wb_sequencer #(
   parameter int LEN_W       = 6,
   parameter int BUS_W       = 4,
   parameter int IRQ_TIMEOUT = 65535
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [BUS_W-1:0] req_bus_i,
   input  logic [6:0]       req_addr_i,
   input  logic             req_rw_i,
   input  logic [LEN_W-1:0] req_len_i,
   input  logic [7:0]       wr_data_i,
   input  logic             wr_valid_i,
   output logic             wr_ready_o,
   output logic [7:0]       rd_data_o,
   output logic             rd_valid_o,
   input  logic             rd_ready_i,
   output logic             done_o,
   output logic [1:0]       status_o,
   output logic             cyc_o,
   output logic             stb_o,
   output logic             we_o,
   output logic [1:0]       adr_o,
   output logic [7:0]       dat_o,
   input  logic [7:0]       dat_i,
   input  logic             ack_i,
   input  logic             irq_i
);
   localparam int CNT_W = $clog2(IRQ_TIMEOUT + 1);

   typedef enum logic [4:0] {
      S_IDLE, S_EN_CSR, S_BUS_DPR, S_BUS_CMD, S_START_CMD, S_ADDR_DPR, S_ADDR_CMD,
      S_WR_WAIT, S_WR_DPR, S_WR_CMD, S_RD_CMD, S_RD_DPR, S_RD_OUT, S_STOP_CMD,
      S_WAIT_IRQ, S_READ_CMDR, S_ABORT
   } state_t;

   state_t state_q, state_d, last_q, last_d;
   logic cyc_q, cyc_d, we_q, we_d, core_en_q, core_en_d, rw_q, rw_d, done_q, done_d;
   logic [1:0] adr_q, adr_d, status_q, status_d;
   logic [7:0] dat_q, dat_d, byte_q, byte_d, rd_data_q, rd_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BUS_W-1:0] bus_q, bus_d;
   logic [6:0] addr_q, addr_d;
   logic [LEN_W-1:0] left_q, left_d;
   logic acc, acc_we, ack_ok;
   logic [1:0] acc_adr;
   logic [7:0] acc_dat;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q   <= S_IDLE;
         last_q    <= S_IDLE;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= 2'd0;
         dat_q     <= 8'h00;
         core_en_q <= 1'b0;
         rw_q      <= 1'b0;
         done_q    <= 1'b0;
         status_q  <= 2'b00;
         byte_q    <= 8'h00;
         rd_data_q <= 8'h00;
         cnt_q     <= '0;
         bus_q     <= '0;
         addr_q    <= 7'd0;
         left_q    <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         core_en_q <= core_en_d;
         rw_q      <= rw_d;
         done_q    <= done_d;
         status_q  <= status_d;
         byte_q    <= byte_d;
         rd_data_q <= rd_data_d;
         cnt_q     <= cnt_d;
         bus_q     <= bus_d;
         addr_q    <= addr_d;
         left_q    <= left_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      core_en_d = core_en_q;
      rw_d      = rw_q;
      done_d    = 1'b0;
      status_d  = status_q;
      byte_d    = byte_q;
      rd_data_d = rd_data_q;
      cnt_d     = cnt_q;
      bus_d     = bus_q;
      addr_d    = addr_q;
      left_d    = left_q;
      acc       = 1'b1;
      acc_we    = 1'b1;
      acc_adr   = 2'd2;
      acc_dat   = 8'h00;

      // Register access each bus-facing state performs; all other states do no access.
      case (state_q)
         S_EN_CSR:    begin acc_adr = 2'd0; acc_dat = 8'hC0; end
         S_BUS_DPR:   begin acc_adr = 2'd1; acc_dat = 8'(bus_q); end
         S_BUS_CMD:   acc_dat = 8'h06;
         S_START_CMD: acc_dat = 8'h04;
         S_ADDR_DPR:  begin acc_adr = 2'd1; acc_dat = {addr_q, rw_q}; end
         S_ADDR_CMD,
         S_WR_CMD:    acc_dat = 8'h01;
         S_WR_DPR:    begin acc_adr = 2'd1; acc_dat = byte_q; end
         S_RD_CMD:    acc_dat = (left_q == LEN_W'(1)) ? 8'h03 : 8'h02;
         S_STOP_CMD:  acc_dat = 8'h05;
         S_READ_CMDR: acc_we = 1'b0;
         S_RD_DPR:    begin acc_we = 1'b0; acc_adr = 2'd1; end
         default:     acc = 1'b0;
      endcase

      ack_ok = acc && cyc_q && ack_i;
      if (acc && !cyc_q) begin
         cyc_d = 1'b1;
         we_d  = acc_we;
         adr_d = acc_adr;
         dat_d = acc_dat;
      end else if (ack_ok) begin
         cyc_d = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               bus_d    = req_bus_i;
               addr_d   = req_addr_i;
               rw_d     = req_rw_i;
               left_d   = req_len_i;
               status_d = 2'b00;
               state_d  = core_en_q ? S_BUS_DPR : S_EN_CSR;
            end
         end
         S_EN_CSR: if (ack_ok) begin core_en_d = 1'b1; state_d = S_BUS_DPR; end
         S_BUS_DPR:  if (ack_ok) state_d = S_BUS_CMD;
         S_ADDR_DPR: if (ack_ok) state_d = S_ADDR_CMD;
         S_WR_DPR:   if (ack_ok) state_d = S_WR_CMD;
         S_BUS_CMD, S_START_CMD, S_ADDR_CMD, S_WR_CMD, S_RD_CMD, S_STOP_CMD: begin
            if (ack_ok) begin
               last_d  = state_q;
               cnt_d   = CNT_W'(IRQ_TIMEOUT);
               state_d = S_WAIT_IRQ;
            end
         end
         S_WAIT_IRQ: begin
            if (irq_i) begin
               state_d = S_READ_CMDR;
            end else if (cnt_q <= CNT_W'(1)) begin
               status_d  = 2'b11;
               core_en_d = 1'b0;
               done_d    = 1'b1;
               state_d   = S_IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_READ_CMDR: begin
            if (ack_ok) begin
               if (dat_i[5]) begin
                  // Arbitration lost: the bus is not ours, so no STOP.
                  status_d = 2'b10;
                  done_d   = 1'b1;
                  state_d  = S_IDLE;
               end else if (dat_i[4]) begin
                  status_d = 2'b11;
                  state_d  = S_ABORT;
               end else if (dat_i[6]) begin
                  if (last_q == S_ADDR_CMD || last_q == S_WR_CMD) begin
                     status_d = 2'b01;
                     state_d  = S_STOP_CMD;
                  end else begin
                     status_d = 2'b11;
                     state_d  = S_ABORT;
                  end
               end else if (!dat_i[7]) begin
                  status_d = 2'b11;
                  state_d  = S_ABORT;
               end else begin
                  case (last_q)
                     S_BUS_CMD:   state_d = S_START_CMD;
                     S_START_CMD: state_d = S_ADDR_DPR;
                     S_ADDR_CMD:  state_d = (left_q == '0) ? S_STOP_CMD : (rw_q ? S_RD_CMD : S_WR_WAIT);
                     S_WR_CMD: begin
                        left_d  = left_q - 1'b1;
                        state_d = (left_q == LEN_W'(1)) ? S_STOP_CMD : S_WR_WAIT;
                     end
                     S_RD_CMD:    state_d = S_RD_DPR;
                     default: begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                     end
                  endcase
               end
            end
         end
         S_WR_WAIT: if (wr_valid_i) begin byte_d = wr_data_i; state_d = S_WR_DPR; end
         S_RD_DPR:  if (ack_ok) begin rd_data_d = dat_i; state_d = S_RD_OUT; end
         S_RD_OUT: begin
            if (rd_ready_i) begin
               left_d  = left_q - 1'b1;
               state_d = (left_q == LEN_W'(1)) ? S_STOP_CMD : S_RD_CMD;
            end
         end
         S_ABORT: begin
            cyc_d     = 1'b0;
            core_en_d = 1'b0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign req_ready_o = (state_q == S_IDLE);
   assign wr_ready_o  = (state_q == S_WR_WAIT) && wr_valid_i;
   assign rd_valid_o  = (state_q == S_RD_OUT);
   assign rd_data_o   = rd_data_q;
   assign done_o      = done_q;
   assign status_o    = status_q;
   assign cyc_o       = cyc_q;
   assign stb_o       = cyc_q;
   assign we_o        = we_q;
   assign adr_o       = adr_q;
   assign dat_o       = dat_q;
endmodule

// File: tb/tb_iicmb_wb_sequencer.sv
// tb/tb_iicmb_wb_sequencer.sv - scoreboard bench for iicmb_wb_sequencer with a behavioural iicmb slave
module tb_iicmb_wb_sequencer;
   localparam int LEN_W = 6;
   localparam int BUS_W = 4;
   localparam int TMO   = 100;
   typedef logic [7:0] u8_t;

   logic clk = 1'b0, rst_n = 1'b0;
   logic req_valid_i = 1'b0, req_rw_i = 1'b0;
   logic [BUS_W-1:0] req_bus_i = '0;
   logic [6:0] req_addr_i = 7'd0;
   logic [LEN_W-1:0] req_len_i = '0;
   logic [7:0] wr_data_i = 8'h00, dat_i = 8'h00;
   logic wr_valid_i = 1'b0, rd_ready_i = 1'b0, ack_i = 1'b0, irq_i = 1'b0;
   logic req_ready_o, wr_ready_o, rd_valid_o, done_o, cyc_o, stb_o, we_o;
   logic [7:0] rd_data_o, dat_o;
   logic [1:0] status_o, adr_o;

   iicmb_wb_sequencer #(.LEN_W(LEN_W), .BUS_W(BUS_W), .IRQ_TIMEOUT(TMO)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_bus_i(req_bus_i),
      .req_addr_i(req_addr_i), .req_rw_i(req_rw_i), .req_len_i(req_len_i),
      .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
      .done_o(done_o), .status_o(status_o),
      .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
      .dat_i(dat_i), .ack_i(ack_i), .irq_i(irq_i)
   );

   always #5 clk = ~clk;

   int total = 0, bad = 0;
   int cyc_no = 0, done_cnt = 0, done_cyc = 0, last_cmd_cyc = 0;
   int wr_hs_total = 0, wr_rdy_cycles = 0, rd_total = 0;
   int stall_left = 0, stall_at = -1;
   bit wr_hs = 0, model_en = 0, no_irq = 0, al_on_start = 0;
   logic [1:0] last_st = 2'b00;
   logic [10:0] exp_wb[$];
   u8_t exp_rd[$], wr_src[$], rd_src[$];
   logic [1:0] exp_st[$];

   // iicmb slave state
   int irq_cnt = 0, ack_dly = 0;
   u8_t stat = 8'h00, dpr_w = 8'h00, dpr_r = 8'h00;
   bit addr_phase = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc_no++;

   task automatic slave_write(input logic [1:0] adr, input u8_t d);
      if (adr == 2'd1) dpr_w = d;
      else if (adr == 2'd2) begin
         stat = 8'h80;
         case (d)
            8'h04: begin stat = al_on_start ? 8'h20 : 8'h80; addr_phase = 1; end
            8'h01: if (addr_phase) begin
                      addr_phase = 0;
                      stat = (dpr_w[7:1] == 7'h22) ? 8'h80 : 8'h40;
                   end
            8'h02, 8'h03: dpr_r = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hEE;
            default: ;
         endcase
         if (!no_irq) irq_cnt = $urandom_range(1, 6);
      end
   endtask

   // Slave responds a little after each rising edge
   always @(posedge clk) begin
      #1;
      if (!rst_n) begin
         ack_i = 0; irq_i = 0; dat_i = 8'h00; irq_cnt = 0; ack_dly = 0; addr_phase = 0;
      end else begin
         if (ack_i) ack_i = 0;
         else if (cyc_o && stb_o) begin
            if (ack_dly > 0) ack_dly--;
            else begin
               ack_i = 1;
               ack_dly = $urandom_range(0, 2);
               if (we_o) slave_write(adr_o, dat_o);
               else if (adr_o == 2'd2) begin dat_i = stat; irq_i = 0; end
               else if (adr_o == 2'd1) dat_i = dpr_r;
               else dat_i = 8'h00;
            end
         end
         if (irq_cnt > 0) begin
            irq_cnt--;
            if (irq_cnt == 0) irq_i = 1;
         end
      end
   end

   // Stream drivers
   always @(posedge clk) begin
      #1;
      if (wr_hs) begin
         if (wr_src.size() > 0) wr_src.delete(0);
         wr_hs = 0;
         wr_valid_i = 0;
      end
      if (!wr_valid_i && wr_src.size() > 0 && $urandom_range(0, 2) != 0) begin
         wr_valid_i = 1;
         wr_data_i = wr_src[0];
      end
      if (stall_left > 0 && rd_valid_o && rd_total == stall_at) begin
         rd_ready_i = 0;
         stall_left--;
      end else rd_ready_i = ($urandom_range(0, 2) != 0);
   end

   // Monitor: compares everything the DUT presents against the scoreboard queues
   always @(negedge clk) begin
      if (rst_n) begin
         if (cyc_o && ack_i) begin
            if (exp_wb.size() == 0) check("wb_unexpected_access", 32'({we_o, adr_o, dat_o}), 32'h7FF);
            else check("wb_access", 32'({we_o, adr_o, we_o ? dat_o : 8'h00}), 32'(exp_wb.pop_front()));
            if (we_o && adr_o == 2'd2) last_cmd_cyc = cyc_no;
         end
         if (wr_valid_i && wr_ready_o) begin wr_hs = 1; wr_hs_total++; end
         if (wr_ready_o) wr_rdy_cycles++;
         if (rd_valid_o) check("no_wb_while_rd_pending", 32'(cyc_o), 32'd0);
         if (rd_valid_o && rd_ready_i) begin
            if (exp_rd.size() == 0) check("rd_unexpected_byte", 32'(rd_data_o), 32'h1FF);
            else check("rd_byte", 32'(rd_data_o), 32'(exp_rd.pop_front()));
            rd_total++;
         end
         if (done_o) begin
            check("req_ready_with_done", 32'(req_ready_o), 32'd1);
            if (exp_st.size() == 0) check("done_unexpected", 32'(status_o), 32'hF);
            else check("status", 32'(status_o), 32'(exp_st.pop_front()));
            done_cnt++;
            done_cyc = cyc_no;
         end
      end
   end

   task automatic push_w(input logic [1:0] adr, input u8_t d);
      exp_wb.push_back({1'b1, adr, d});
   endtask

   task automatic push_cmd(input u8_t c);
      push_w(2'd2, c);
      exp_wb.push_back({1'b0, 2'd2, 8'h00});
   endtask

   // Expected register traffic derived from the transaction rules
   task automatic model(input logic [3:0] bus, input logic [6:0] addr, input logic rw,
                        input int len, input u8_t d[$]);
      if (!model_en) begin push_w(2'd0, 8'hC0); model_en = 1; end
      push_w(2'd1, 8'(bus));
      if (no_irq) begin
         push_w(2'd2, 8'h06);
         exp_st.push_back(2'b11); last_st = 2'b11; model_en = 0;
         return;
      end
      push_cmd(8'h06);
      push_cmd(8'h04);
      if (al_on_start) begin exp_st.push_back(2'b10); last_st = 2'b10; return; end
      push_w(2'd1, {addr, rw});
      push_cmd(8'h01);
      if (addr != 7'h22) begin
         push_cmd(8'h05);
         exp_st.push_back(2'b01); last_st = 2'b01;
         return;
      end
      for (int i = 0; i < len; i++) begin
         if (!rw) begin
            push_w(2'd1, d[i]);
            push_cmd(8'h01);
         end else begin
            push_cmd((i == len - 1) ? 8'h03 : 8'h02);
            exp_wb.push_back({1'b0, 2'd1, 8'h00});
            exp_rd.push_back(d[i]);
         end
      end
      push_cmd(8'h05);
      exp_st.push_back(2'b00); last_st = 2'b00;
   endtask

   task automatic do_req(input logic [3:0] bus, input logic [6:0] addr, input logic rw, input int len);
      @(negedge clk);
      check("req_ready_before_req", 32'(req_ready_o), 32'd1);
      req_bus_i = bus; req_addr_i = addr; req_rw_i = rw; req_len_i = LEN_W'(len);
      req_valid_i = 1;
      @(negedge clk);
      req_valid_i = 0;
   endtask

   task automatic wait_done(input int budget);
      int start = done_cnt;
      int n = 0;
      while (done_cnt == start && n < budget) begin @(negedge clk); n++; end
      check("done_within_budget", 32'(done_cnt != start), 32'd1);
   endtask

   task automatic flush_streams();
      wr_src.delete(); rd_src.delete();
      wr_valid_i = 0; wr_hs = 0;
   endtask

   task automatic txn(input logic [3:0] bus, input logic [6:0] addr, input logic rw,
                      input int len, input bit seq, input int base);
      u8_t d[$];
      int wr0 = wr_rdy_cycles;
      int exp_wr = (!rw && addr == 7'h22 && !al_on_start && !no_irq) ? len : 0;
      for (int i = 0; i < len; i++) d.push_back(seq ? u8_t'(base + i) : u8_t'($urandom));
      model(bus, addr, rw, len, d);
      foreach (d[i]) if (rw) rd_src.push_back(d[i]); else wr_src.push_back(d[i]);
      do_req(bus, addr, rw, len);
      wait_done(20000);
      repeat (3) @(negedge clk);
      check("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
      check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
      check("wr_ready_cycles", 32'(wr_rdy_cycles - wr0), 32'(exp_wr));
      check("status_held", 32'(status_o), 32'(last_st));
      flush_streams();
   endtask

   initial begin
      int found, n, d;
      repeat (2) @(negedge clk);
      check("reset_outputs_zero",
            32'({cyc_o, stb_o, we_o, adr_o, dat_o, done_o, status_o, wr_ready_o, rd_valid_o, rd_data_o}), 32'd0);
      check("reset_req_ready", 32'(req_ready_o), 32'd1);
      rst_n = 1;

      txn(4'd0, 7'h22, 1'b0, 32, 1, 0);
      txn(4'd0, 7'h22, 1'b1, 32, 1, 100);

      stall_at = rd_total + 2; stall_left = 50;
      txn(4'd1, 7'h22, 1'b1, 4, 0, 0);
      check("rd_stall_applied", 32'(stall_left), 32'd0);

      txn(4'd2, 7'h10, 1'b0, 2, 0, 0);
      txn(4'd0, 7'h22, 1'b0, 0, 0, 0);

      al_on_start = 1;
      txn(4'd3, 7'h22, 1'b1, 3, 0, 0);
      al_on_start = 0;

      no_irq = 1;
      txn(4'd1, 7'h22, 1'b0, 2, 0, 0);
      no_irq = 0;
      d = done_cyc - last_cmd_cyc;
      check("timeout_latency_100_to_102", 32'(d >= 100 && d <= 102), 32'd1);

      for (int k = 0; k < 8; k++)
         txn(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 7'h10 : 7'h22,
             1'($urandom_range(0, 1)), $urandom_range(0, 10), 0, 0);

      // Reset in the middle of a data-byte DPR write
      begin
         u8_t dd[$];
         int hs0 = wr_hs_total;
         for (int i = 0; i < 8; i++) dd.push_back(u8_t'($urandom));
         model(4'd0, 7'h22, 1'b0, 8, dd);
         foreach (dd[i]) wr_src.push_back(dd[i]);
         do_req(4'd0, 7'h22, 1'b0, 8);
         found = 0; n = 0;
         while (!found && n < 5000) begin
            @(negedge clk); n++;
            if (wr_hs_total >= hs0 + 2 && cyc_o && we_o && adr_o == 2'd1) found = 1;
         end
         check("reached_wr_byte_access", 32'(found), 32'd1);
         #2 rst_n = 0;
         #1;
         check("reset_drops_cyc", 32'({cyc_o, stb_o}), 32'd0);
         check("reset_req_ready_mid", 32'(req_ready_o), 32'd1);
         exp_wb.delete(); exp_rd.delete(); exp_st.delete();
         flush_streams();
         model_en = 0;
         repeat (2) @(negedge clk);
         rst_n = 1;
      end
      txn(4'd5, 7'h22, 1'b0, 3, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
